keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 240 ++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks a single active-low column across the
// keypad, synchronizes and samples the rows, resolves one key per full scan
// and debounces presses/releases into a one-cycle key_valid strobe plus a
// key_held level.
module keypad_scanner #(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int             DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam int             CW         = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0]  CNT_DONE   = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO   = CW'(0);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  // Anything that is not a solid 0 (X, Z, 1) reads as "not pressed".
  function automatic logic [3:0] clean_rows(input logic [3:0] raw);
    logic [3:0] res;
    res = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      if (raw[i] == 1'b0) begin
        res[i] = 1'b0;
      end else begin
        res[i] = 1'b1;
      end
    end
    return res;
  endfunction

  logic [3:0]    sync1_r, sync2_r;
  logic [DW-1:0] dwell_r;
  logic [1:0]    col_idx_r;
  logic          acc_found_r;
  logic [3:0]    acc_code_r;
  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [3:0]    cand_r, cand_s;
  logic [3:0]    key_code_r, key_code_s;
  logic          key_valid_r, key_valid_s;
  logic          key_held_r, key_held_s;

  logic          sample_s;
  logic          result_valid_s;
  logic          cur_hit_s;
  logic [1:0]    cur_row_s;
  logic          res_found_s;
  logic [3:0]    res_code_s;

  // Two-flop synchronizer on the asynchronous row inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 4'b1111;
      sync2_r <= 4'b1111;
    end else begin
      sync1_r <= clean_rows(key_row);
      sync2_r <= sync1_r;
    end
  end

  // Dwell counter and column index; column advances on the dwell wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_r   <= '0;
      col_idx_r <= 2'd0;
    end else if (dwell_r == DWELL_LAST) begin
      dwell_r   <= '0;
      col_idx_r <= col_idx_r + 2'd1;
    end else begin
      dwell_r   <= dwell_r + DW'(1);
      col_idx_r <= col_idx_r;
    end
  end

  // Active column is pulled low, all others float.
  for (genvar g = 0; g < 4; g++) begin : g_col
    assign key_col[g] = (col_idx_r == 2'(g)) ? 1'b0 : 1'bz;
  end

  assign sample_s       = (dwell_r == DWELL_LAST);
  assign result_valid_s = sample_s && (col_idx_r == 2'd3);

  // Row decode of the current column: lowest pressed row wins.
  always_comb begin
    cur_hit_s = ~&sync2_r;
    cur_row_s = 2'd3;
    if (sync2_r[0] == 1'b0) begin
      cur_row_s = 2'd0;
    end else if (sync2_r[1] == 1'b0) begin
      cur_row_s = 2'd1;
    end else if (sync2_r[2] == 1'b0) begin
      cur_row_s = 2'd2;
    end else begin
      cur_row_s = 2'd3;
    end
  end

  // Merge this column into the running scan result; an earlier column wins.
  always_comb begin
    res_found_s = 1'b0;
    res_code_s  = 4'h0;
    if ((col_idx_r != 2'd0) && acc_found_r) begin
      res_found_s = 1'b1;
      res_code_s  = acc_code_r;
    end else begin
      res_found_s = cur_hit_s;
      res_code_s  = {cur_row_s, col_idx_r};
    end
  end

  // Running scan accumulator, restarted by the column-0 sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_found_r <= 1'b0;
      acc_code_r  <= 4'h0;
    end else if (sample_s) begin
      acc_found_r <= res_found_s;
      acc_code_r  <= res_code_s;
    end else begin
      acc_found_r <= acc_found_r;
      acc_code_r  <= acc_code_r;
    end
  end

  // Debounce FSM state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      cand_r      <= 4'h0;
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      cand_r      <= cand_s;
      key_code_r  <= key_code_s;
      key_valid_r <= key_valid_s;
      key_held_r  <= key_held_s;
    end
  end

  // Debounce FSM next state, evaluated once per completed scan.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    cand_s      = cand_r;
    key_code_s  = key_code_r;
    key_valid_s = 1'b0;
    key_held_s  = key_held_r;
    if (result_valid_s) begin
      case (state_r)
        IDLE: begin
          if (res_found_s) begin
            cand_s = res_code_s;
            if (DEBOUNCE_SCANS == 1) begin
              key_code_s  = res_code_s;
              key_valid_s = 1'b1;
              key_held_s  = 1'b1;
              state_s     = PRESSED;
              cnt_s       = CNT_ZERO;
            end else begin
              state_s = PRESS_DB;
              cnt_s   = CNT_ONE;
            end
          end else begin
            cnt_s = CNT_ZERO;
          end
        end
        PRESS_DB: begin
          if (res_found_s && (res_code_s == cand_r)) begin
            if ((cnt_r + CNT_ONE) == CNT_DONE) begin
              key_code_s  = cand_r;
              key_valid_s = 1'b1;
              key_held_s  = 1'b1;
              state_s     = PRESSED;
              cnt_s       = CNT_ZERO;
            end else begin
              cnt_s = cnt_r + CNT_ONE;
            end
          end else begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
          end
        end
        PRESSED: begin
          if (res_found_s && (res_code_s == key_code_r)) begin
            cnt_s = CNT_ZERO;
          end else if (DEBOUNCE_SCANS == 1) begin
            key_held_s = 1'b0;
            state_s    = IDLE;
            cnt_s      = CNT_ZERO;
          end else begin
            state_s = RELEASE_DB;
            cnt_s   = CNT_ONE;
          end
        end
        RELEASE_DB: begin
          if (res_found_s && (res_code_s == key_code_r)) begin
            state_s = PRESSED;
            cnt_s   = CNT_ZERO;
          end else if ((cnt_r + CNT_ONE) == CNT_DONE) begin
            key_held_s = 1'b0;
            state_s    = IDLE;
            cnt_s      = CNT_ZERO;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a scan-level reference model predicts
// accepted key codes into a queue; a monitor pops and compares on key_valid.
module tb_keypad_scanner;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 3;

  logic        clk;
  logic        rst;
  logic [3:0]  key_row;
  wire  [3:0]  key_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] cur_set;        // bit (row*4+col) set = key physically pressed
  int          vectors;
  int          fails;

  // Reference model state (scan granularity)
  logic [3:0]  exp_q[$];
  int          run_len;
  logic [3:0]  run_code;
  int          miss_len;
  bit          held_m;
  logic [3:0]  code_m;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) dut (
    .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  for (genvar g = 0; g < 4; g++) begin : g_pu
    pullup (key_col[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a pressed key connects its column to its row.
  always_comb begin
    key_row = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      if (key_col[c] == 1'b0) begin
        for (int r = 0; r < 4; r++) begin
          if (cur_set[r*4+c]) key_row[r] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Resolve a pressed set: lowest column first, then lowest row.
  task automatic resolve(input logic [15:0] set, output bit found, output logic [3:0] code);
    found = 1'b0;
    code  = 4'h0;
    for (int c = 3; c >= 0; c--) begin
      for (int r = 3; r >= 0; r--) begin
        if (set[r*4+c]) begin
          found = 1'b1;
          code  = 4'(r*4+c);
        end
      end
    end
  endtask

  task automatic model_reset();
    run_len  = 0;
    miss_len = 0;
    held_m   = 1'b0;
    code_m   = 4'h0;
    run_code = 4'h0;
  endtask

  // Apply the rules to one full-scan result.
  task automatic model_scan(input logic [15:0] set);
    bit         f;
    logic [3:0] c;
    resolve(set, f, c);
    if (!held_m) begin
      if (f && run_len > 0) begin
        if (c == run_code) run_len++;
        else run_len = 0;
      end else if (f) begin
        run_code = c;
        run_len  = 1;
      end else begin
        run_len = 0;
      end
      if (run_len == DEBOUNCE_SCANS) begin
        exp_q.push_back(run_code);
        held_m   = 1'b1;
        code_m   = run_code;
        miss_len = 0;
        run_len  = 0;
      end
    end else begin
      if (f && c == code_m) miss_len = 0;
      else miss_len++;
      if (miss_len == DEBOUNCE_SCANS) begin
        held_m   = 1'b0;
        miss_len = 0;
      end
    end
  endtask

  // Wait until the scan wraps from column 3 back to column 0.
  task automatic wait_boundary();
    logic [3:0] prev;
    bit ok;
    ok   = 1'b0;
    prev = key_col;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && key_col == 4'b1110) ok = 1'b1;
      prev = key_col;
    end
    if (!ok) begin
      vectors++;
      fails++;
      $display("FAIL scan_boundary_timeout: got no column wrap, expected one within 40 cycles");
    end
  endtask

  // Hold one pressed set for exactly one scan, then check the level outputs.
  task automatic run_scan(input logic [15:0] set);
    cur_set = set;
    model_scan(set);
    wait_boundary();
    chk("key_held", {3'b000, key_held}, {3'b000, held_m});
    chk("key_code", key_code, code_m);
  endtask

  // Monitor: every key_valid pulse must match the next predicted event.
  always @(negedge clk) begin
    if (rst && key_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        fails++;
        $display("FAIL spurious_valid: got key_valid=1 code %h, expected no event", key_code);
      end else begin
        chk("valid_code", key_code, exp_q.pop_front());
        chk("held_at_valid", {3'b000, key_held}, 4'h1);
      end
    end
  end

  initial begin
    logic [15:0] s;
    vectors = 0;
    fails   = 0;
    cur_set = 16'h0000;
    model_reset();
    rst = 1'b0;

    // 1. Reset and column walk
    repeat (3) @(negedge clk);
    chk("rst_key_col", key_col, 4'b1110);
    chk("rst_key_valid", {3'b000, key_valid}, 4'h0);
    chk("rst_key_held", {3'b000, key_held}, 4'h0);
    chk("rst_key_code", key_code, 4'h0);
    rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("col_walk", key_col, ~(4'b0001 << ((k / 4) % 4)));
    end

    // 2. Single press (row1/col2 -> 6), held well past 200 cycles
    for (int i = 0; i < 16; i++) run_scan(16'h0040);
    // 3. Release
    for (int i = 0; i < 5; i++) run_scan(16'h0000);

    // 4. Bounce on row3/col0 (code C), then steady
    for (int i = 0; i < 5; i++) begin
      run_scan(16'h1000);
      run_scan(16'h0000);
    end
    for (int i = 0; i < 5; i++) run_scan(16'h1000);
    for (int i = 0; i < 5; i++) run_scan(16'h0000);

    // 5. Multi-key: codes 1 and B -> 1; then add code 4 while held
    for (int i = 0; i < 5; i++) run_scan(16'h0802);
    for (int i = 0; i < 8; i++) run_scan(16'h0812);
    for (int i = 0; i < 5; i++) run_scan(16'h0000);

    // 6. Reset after two matching scans of code 6
    run_scan(16'h0040);
    run_scan(16'h0040);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("midrst_key_held", {3'b000, key_held}, 4'h0);
    chk("midrst_key_code", key_code, 4'h0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) run_scan(16'h0040);
    for (int i = 0; i < 5; i++) run_scan(16'h0000);

    // Randomized segments
    s = 16'h0000;
    for (int seg = 0; seg < 60; seg++) begin
      case ($urandom_range(0, 3))
        0: s = 16'h0000;
        1: s = 16'h0001 << $urandom_range(0, 15);
        2: s = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
        default: s = s;
      endcase
      for (int n = 0, len = $urandom_range(1, 5); n < len; n++) run_scan(s);
    end
    for (int i = 0; i < 5; i++) run_scan(16'h0000);

    chk("pending_events", 4'(exp_q.size()), 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
